// File: rtl/lcd_pkg.sv
// Shared types, opcode masks and cursor helpers
// for the HD44780-style LCD bus monitor.
package lcd_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    localparam int LINE_LEN = 16;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;

    localparam logic [7:0] CLEAR_M = 8'hFF;
    localparam logic [7:0] CLEAR_P = 8'h01;
    localparam logic [7:0] HOME_M  = 8'hFE;
    localparam logic [7:0] HOME_P  = 8'h02;
    localparam logic [7:0] ENTRY_M = 8'hFC;
    localparam logic [7:0] ENTRY_P = 8'h04;
    localparam logic [7:0] DISP_M  = 8'hF8;
    localparam logic [7:0] DISP_P  = 8'h08;
    localparam logic [7:0] SHIFT_M = 8'hF0;
    localparam logic [7:0] SHIFT_P = 8'h10;
    localparam logic [7:0] FUNC_M  = 8'hE0;
    localparam logic [7:0] FUNC_P  = 8'h20;
    localparam logic [7:0] CGRAM_M = 8'hC0;
    localparam logic [7:0] CGRAM_P = 8'h40;
    localparam logic [7:0] DDRAM_M = 8'h80;
    localparam logic [7:0] DDRAM_P = 8'h80;

    function automatic logic op_is(
        input logic [7:0] d,
        input logic [7:0] m,
        input logic [7:0] p
    );
        return (d & m) == p;
    endfunction

    // Only the two visible 16-column windows are legal.
    function automatic logic addr_ok(input logic [6:0] a);
        logic [6:0] base;
        base = a & ~7'(LINE_LEN - 1);
        return (base == LINE1_BASE) || (base == LINE2_BASE);
    endfunction

    // Step within the 32 visible cells, hopping between lines.
    function automatic logic [6:0] cur_step(
        input logic [6:0] c,
        input logic       inc
    );
        logic [6:0] r;
        if (inc) begin
            if (c[3:0] == 4'hF)
                r = c[6] ? LINE1_BASE : LINE2_BASE;
            else
                r = c + 7'd1;
        end else begin
            if (c[3:0] == 4'h0)
                r = c[6] ? LINE1_BASE + 7'(LINE_LEN - 1)
                         : LINE2_BASE + 7'(LINE_LEN - 1);
            else
                r = c - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Synchronizes RS/E/D into the clock domain and flags
// the falling edge of E with the last data captured.
module lcd_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rs_i,
    input  logic       e_i,
    input  logic [7:0] d_i,
    output logic       fall_o,
    output logic       rs_o,
    output logic [7:0] d_o
);

    logic [SYNC_STAGES-1:0] rs_q;
    logic [SYNC_STAGES-1:0] e_q;
    logic [7:0]             d_q [SYNC_STAGES];
    logic                   e_prev_q;
    logic                   cap_rs_q;
    logic [7:0]             cap_d_q;

    logic       e_s;
    logic       rs_s;
    logic [7:0] d_s;

    assign e_s  = e_q[SYNC_STAGES-1];
    assign rs_s = rs_q[SYNC_STAGES-1];
    assign d_s  = d_q[SYNC_STAGES-1];

    // Shift chains, edge history and capture while E is high.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rs_q     <= '0;
            e_q      <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                d_q[i] <= '0;
            e_prev_q <= 1'b0;
            cap_rs_q <= 1'b0;
            cap_d_q  <= '0;
        end else begin
            rs_q   <= {rs_q[SYNC_STAGES-2:0], rs_i};
            e_q    <= {e_q[SYNC_STAGES-2:0], e_i};
            d_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                d_q[i] <= d_q[i-1];
            e_prev_q <= e_s;
            if (e_s) begin
                cap_rs_q <= rs_s;
                cap_d_q  <= d_s;
            end
        end
    end

    assign fall_o = e_prev_q & ~e_s;
    assign rs_o   = cap_rs_q;
    assign d_o    = cap_d_q;

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive LCD bus snooper: decodes writer transfers and
// keeps a 2x16 shadow of the display contents.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_CHAR   = 8'h20
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       RS,
    input  logic       E,
    input  logic [7:0] D,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       xfer_valid,
    output logic       xfer_rs,
    output logic [7:0] xfer_data,
    output logic [6:0] cursor,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       err_overrun,
    output logic       err_addr,
    output logic       err_mode
);

    logic       fall;
    logic       cap_rs;
    logic [7:0] cap_d;

    lcd_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (CLOCK_50),
        .rst_n_i (RESET_N),
        .rs_i    (RS),
        .e_i     (E),
        .d_i     (D),
        .fall_o  (fall),
        .rs_o    (cap_rs),
        .d_o     (cap_d)
    );

    state_e     state_q;
    logic [4:0] fill_idx_q;
    logic [6:0] cursor_q;
    logic       cgram_q;
    logic       disp_q;
    logic       curon_q;
    logic       blink_q;
    logic       inc_q;
    logic       ovr_q;
    logic       addr_q;
    logic       mode_q;
    logic       xv_q;
    logic       xrs_q;
    logic [7:0] xd_q;
    logic [7:0] rd_q;
    logic [7:0] shadow [32];

    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;

    // One shadow write port shared by fill and data writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = fill_idx_q;
        wr_data = FILL_CHAR;
        if (state_q == ST_FILL) begin
            wr_en = 1'b1;
        end else if (fall && cap_rs && !cgram_q) begin
            wr_en   = 1'b1;
            wr_idx  = {cursor_q[6], cursor_q[3:0]};
            wr_data = cap_d;
        end
    end

    // Shadow array; contents are established by the fill pass.
    always_ff @(posedge CLOCK_50) begin
        if (RESET_N && wr_en)
            shadow[wr_idx] <= wr_data;
    end

    // Registered read, old data wins on a same-cycle write.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N)
            rd_q <= '0;
        else
            rd_q <= shadow[rd_addr];
    end

    // Control FSM: fill sequencing and transfer decode.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q    <= ST_FILL;
            fill_idx_q <= '0;
            cursor_q   <= LINE1_BASE;
            cgram_q    <= 1'b0;
            disp_q     <= 1'b0;
            curon_q    <= 1'b0;
            blink_q    <= 1'b0;
            inc_q      <= 1'b1;
            ovr_q      <= 1'b0;
            addr_q     <= 1'b0;
            mode_q     <= 1'b0;
            xv_q       <= 1'b0;
            xrs_q      <= 1'b0;
            xd_q       <= '0;
        end else begin
            xv_q <= fall;
            if (fall) begin
                xrs_q <= cap_rs;
                xd_q  <= cap_d;
            end
            unique case (state_q)
                ST_FILL: begin
                    fill_idx_q <= fill_idx_q + 5'd1;
                    if (fill_idx_q == 5'd31)
                        state_q <= ST_IDLE;
                    if (fall)
                        ovr_q <= 1'b1;
                end
                ST_IDLE: begin
                    if (fall && cap_rs) begin
                        if (!cgram_q)
                            cursor_q <= cur_step(cursor_q, inc_q);
                    end else if (fall) begin
                        unique case (1'b1)
                            op_is(cap_d, DDRAM_M, DDRAM_P): begin
                                if (addr_ok(cap_d[6:0]))
                                    cursor_q <= cap_d[6:0];
                                else
                                    addr_q <= 1'b1;
                                cgram_q <= 1'b0;
                            end
                            op_is(cap_d, CGRAM_M, CGRAM_P):
                                cgram_q <= 1'b1;
                            op_is(cap_d, FUNC_M, FUNC_P): begin
                                if (!cap_d[4])
                                    mode_q <= 1'b1;
                            end
                            op_is(cap_d, SHIFT_M, SHIFT_P): begin
                                if (!cap_d[3])
                                    cursor_q <= cur_step(cursor_q, cap_d[2]);
                            end
                            op_is(cap_d, DISP_M, DISP_P): begin
                                disp_q  <= cap_d[2];
                                curon_q <= cap_d[1];
                                blink_q <= cap_d[0];
                            end
                            op_is(cap_d, ENTRY_M, ENTRY_P):
                                inc_q <= cap_d[1];
                            op_is(cap_d, HOME_M, HOME_P):
                                cursor_q <= LINE1_BASE;
                            op_is(cap_d, CLEAR_M, CLEAR_P): begin
                                state_q    <= ST_FILL;
                                fill_idx_q <= '0;
                                cursor_q   <= LINE1_BASE;
                                inc_q      <= 1'b1;
                                cgram_q    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_char     = rd_q;
    assign xfer_valid  = xv_q;
    assign xfer_rs     = xrs_q;
    assign xfer_data   = xd_q;
    assign cursor      = cursor_q;
    assign disp_on     = disp_q;
    assign cursor_on   = curon_q;
    assign blink_on    = blink_q;
    assign entry_inc   = inc_q;
    assign busy        = (state_q == ST_FILL);
    assign err_overrun = ovr_q;
    assign err_addr    = addr_q;
    assign err_mode    = mode_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Self-checking bench for lcd_bus_monitor: per-cycle
// behavioural model plus directed literal scenarios.
module tb_lcd_bus_monitor;

    localparam int         N    = 2;
    localparam logic [7:0] FILL = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs = 1'b0;
    logic       e = 1'b0;
    logic [7:0] d = 8'h00;
    logic [4:0] rd_addr = 5'd0;

    logic [7:0] rd_char;
    logic       xfer_valid;
    logic       xfer_rs;
    logic [7:0] xfer_data;
    logic [6:0] cursor;
    logic       disp_on, cursor_on, blink_on, entry_inc;
    logic       busy, err_overrun, err_addr, err_mode;

    always #10 clk = ~clk;

    lcd_bus_monitor #(
        .SYNC_STAGES (N),
        .FILL_CHAR   (FILL)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .RS          (rs),
        .E           (e),
        .D           (d),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .xfer_valid  (xfer_valid),
        .xfer_rs     (xfer_rs),
        .xfer_data   (xfer_data),
        .cursor      (cursor),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .entry_inc   (entry_inc),
        .busy        (busy),
        .err_overrun (err_overrun),
        .err_addr    (err_addr),
        .err_mode    (err_mode)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    bit         eh [64];
    bit         rsh [64];
    logic [7:0] dh [64];
    logic [7:0] m_sh [32];
    bit         m_vld [32];
    int         pos, fill_left;
    bit         m_ent, m_cg, m_disp, m_con, m_blk;
    bit         m_ovr, m_adr, m_mod;
    bit         x_v, x_rs;
    logic [7:0] x_d, x_rd;
    bit         x_rd_chk;

    function automatic int pos2cur(input int p);
        return (p / 16) * 64 + (p % 16);
    endfunction

    task automatic decode(input bit r, input logic [7:0] v);
        int a;
        if (r) begin
            if (!m_cg) begin
                m_sh[pos]  = v;
                m_vld[pos] = 1;
                pos = m_ent ? (pos + 1) % 32 : (pos + 31) % 32;
            end
        end else if (v >= 8'h80) begin
            a = int'(v) - 128;
            if (a <= 15) pos = a;
            else if (a >= 64 && a <= 79) pos = 16 + a - 64;
            else m_adr = 1;
            m_cg = 0;
        end else if (v >= 8'h40) begin
            m_cg = 1;
        end else if (v >= 8'h20) begin
            if (v[4] == 1'b0) m_mod = 1;
        end else if (v >= 8'h10) begin
            if (v[3] == 1'b0)
                pos = v[2] ? (pos + 1) % 32 : (pos + 31) % 32;
        end else if (v >= 8'h08) begin
            m_disp = v[2];
            m_con  = v[1];
            m_blk  = v[0];
        end else if (v >= 8'h04) begin
            m_ent = v[1];
        end else if (v >= 8'h02) begin
            pos = 0;
        end else if (v == 8'h01) begin
            fill_left = 32;
            pos = 0;
            m_ent = 1;
            m_cg = 0;
        end
    endtask

    task automatic model_step();
        int  t, f;
        bit  fire, bp;
        cyc++;
        t = cyc;
        if (!rst_n) begin
            eh[t%64]  = 0;
            rsh[t%64] = 0;
            dh[t%64]  = 8'h00;
            for (int i = 0; i < 32; i++) m_vld[i] = 0;
            pos = 0; fill_left = 32;
            m_ent = 1; m_cg = 0;
            m_disp = 0; m_con = 0; m_blk = 0;
            m_ovr = 0; m_adr = 0; m_mod = 0;
            x_v = 0; x_rs = 0; x_d = 8'h00;
            x_rd = 8'h00; x_rd_chk = 1;
            return;
        end
        eh[t%64]  = e;
        rsh[t%64] = rs;
        dh[t%64]  = d;
        x_rd_chk = m_vld[rd_addr];
        x_rd     = m_sh[rd_addr];
        f = t - N;
        fire = (f >= 1) && !eh[f%64] && eh[(f-1)%64];
        x_v = fire;
        bp = fill_left > 0;
        if (bp) begin
            m_sh[32-fill_left]  = FILL;
            m_vld[32-fill_left] = 1;
            fill_left--;
        end
        if (fire) begin
            x_rs = rsh[(f-1)%64];
            x_d  = dh[(f-1)%64];
            if (bp) m_ovr = 1;
            else decode(x_rs, x_d);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process ----------------
    int xv_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            if (xfer_valid === 1'b1) xv_cnt++;
            chk("xfer_valid", xfer_valid, x_v);
            chk("xfer_rs", xfer_rs, x_rs);
            chk("xfer_data", xfer_data, x_d);
            chk("cursor", cursor, pos2cur(pos));
            chk("disp_on", disp_on, m_disp);
            chk("cursor_on", cursor_on, m_con);
            chk("blink_on", blink_on, m_blk);
            chk("entry_inc", entry_inc, m_ent);
            chk("busy", busy, fill_left > 0);
            chk("err_overrun", err_overrun, m_ovr);
            chk("err_addr", err_addr, m_adr);
            chk("err_mode", err_mode, m_mod);
            if (x_rd_chk) chk("rd_char", rd_char, x_rd);
        end
    end

    // ---------------- stimulus ----------------
    bit rd_rand = 0;

    initial forever begin
        @(negedge clk);
        if (rd_rand) rd_addr = 5'($urandom_range(31, 0));
    end

    task automatic wr(input bit r, input logic [7:0] v,
                      input int hi = 2, input int gap = 6);
        rs = r; d = v; e = 1'b1;
        repeat (hi) @(negedge clk);
        e = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rd_chk(input int a, input logic [7:0] exp);
        rd_addr = 5'(a);
        @(negedge clk);
        chk($sformatf("lit_rd[%0d]", a), rd_char, exp);
    endtask

    task automatic sweep(input logic [7:0] exp);
        for (int i = 0; i < 32; i++) rd_chk(i, exp);
    endtask

    task automatic rand_wr();
        logic [7:0] v;
        bit r;
        int k;
        r = $urandom_range(1, 0) == 1;
        k = $urandom_range(9, 0);
        v = 8'($urandom);
        if (!r && k < 5) begin
            case (k)
                0: v = 8'h80 | 8'($urandom_range(15, 0));
                1: v = 8'hC0 | 8'($urandom_range(15, 0));
                2: v = 8'h10 | 8'($urandom_range(15, 0));
                3: v = 8'h04 | 8'($urandom_range(3, 0));
                default: v = 8'h08 | 8'($urandom_range(7, 0));
            endcase
        end
        rs = r; d = v; e = 1'b1;
        repeat ($urandom_range(4, 1)) begin
            @(negedge clk);
            if ($urandom_range(3, 0) == 0) d = 8'($urandom);
        end
        e = 1'b0;
        repeat ($urandom_range(6, 1)) @(negedge clk);
    endtask

    initial begin : main
        int xv0;
        bit seen;
        repeat (5) @(negedge clk);
        chk("lit_reset_rd", rd_char, 8'h00);
        chk("lit_reset_busy", busy, 1'b1);
        chk("lit_reset_inc", entry_inc, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("lit_busy_c1", busy, 1'b1);
        repeat (30) @(negedge clk);
        chk("lit_busy_c31", busy, 1'b1);
        @(negedge clk);
        chk("lit_busy_c32", busy, 1'b0);
        sweep(8'h20);

        wr(0, 8'h06); wr(0, 8'h0C);
        wr(1, 8'h41); wr(1, 8'h42);
        chk("lit_cur02", cursor, 7'h02);
        chk("lit_disp", disp_on, 1'b1);
        chk("lit_curon", cursor_on, 1'b0);
        rd_chk(0, 8'h41); rd_chk(1, 8'h42);

        wr(0, 8'h8F); wr(1, 8'h58); wr(1, 8'h59);
        rd_chk(15, 8'h58); rd_chk(16, 8'h59);
        chk("lit_cur41", cursor, 7'h41);
        wr(0, 8'h04); wr(0, 8'hC0); wr(1, 8'h5A);
        rd_chk(16, 8'h5A);
        chk("lit_cur0f", cursor, 7'h0F);

        rs = 1'b0; d = 8'h01; e = 1'b1;
        repeat (2) @(negedge clk);
        e = 1'b0;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (xfer_valid === 1'b1) seen = 1;
        end
        if (!seen) chk("clear_xfer_timeout", 0, 1);
        repeat (2) @(negedge clk);
        wr(1, 8'h41, 1, 40);
        chk("lit_overrun", err_overrun, 1'b1);
        chk("lit_cur00", cursor, 7'h00);
        sweep(8'h20);

        wr(0, 8'h95);
        chk("lit_err_addr", err_addr, 1'b1);
        chk("lit_cur_keep", cursor, 7'h00);
        wr(0, 8'h40); wr(1, 8'h1F);
        rd_chk(0, 8'h20);
        chk("lit_cg_cur", cursor, 7'h00);
        wr(0, 8'h80); wr(1, 8'h33);
        rd_chk(0, 8'h33);
        wr(0, 8'h30);
        chk("lit_mode_ok", err_mode, 1'b0);
        wr(0, 8'h20);
        chk("lit_mode_err", err_mode, 1'b1);
        wr(0, 8'h10); wr(0, 8'h10);
        chk("lit_wrap4f", cursor, 7'h4F);
        wr(0, 8'h14);
        chk("lit_wrap00", cursor, 7'h00);

        xv0 = xv_cnt;
        rs = 1'b1; d = 8'h61; e = 1'b1;
        @(negedge clk);
        d = 8'h62;
        repeat (2) @(negedge clk);
        e = 1'b0;
        repeat (8) @(negedge clk);
        chk("lit_one_xfer", xv_cnt - xv0, 1);
        chk("lit_final_d", xfer_data, 8'h62);
        rd_chk(0, 8'h62);

        rd_rand = 1;
        repeat (250) rand_wr();
        rs = 1'b0; d = 8'h8A; e = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        e = 1'b0;
        rst_n = 1'b1;
        repeat (150) rand_wr();
        rd_rand = 0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
